// File: rtl/serial_command_initiator_pkg.sv
// Shared definitions for the serial memory-access protocol: command and ack
// bytes, frame lengths, FSM state encodings, the latched request payload and
// the frame byte selector.
package serial_command_initiator_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;

  localparam logic [BYTE_W-1:0] CMD_WRITE_WORD   = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ_WORD    = 8'h02;
  localparam logic [BYTE_W-1:0] ACK_BYTE_DEFAULT = 8'hAA;

  localparam int unsigned WRITE_FRAME_BYTES = 9;
  localparam int unsigned READ_FRAME_BYTES  = 5;
  localparam int unsigned READ_REPLY_BYTES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_RECV,
    S_DONE
  } initiatorState_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } senderPhase_e;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
  } memRequest_t;

  // Byte idx of the command frame: command, address MSB first, then data MSB first.
  function automatic logic [BYTE_W-1:0] frameByte(input memRequest_t r,
                                                  input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      4'd0:    b = r.write ? CMD_WRITE_WORD : CMD_READ_WORD;
      4'd1:    b = r.address[31:24];
      4'd2:    b = r.address[23:16];
      4'd3:    b = r.address[15:8];
      4'd4:    b = r.address[7:0];
      4'd5:    b = r.data[31:24];
      4'd6:    b = r.data[23:16];
      4'd7:    b = r.data[15:8];
      4'd8:    b = r.data[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic logic [IDX_W-1:0] lastFrameIdx(input logic write);
    return write ? IDX_W'(WRITE_FRAME_BYTES - 1) : IDX_W'(READ_FRAME_BYTES - 1);
  endfunction

endpackage

// File: rtl/serial_command_initiator_byte_sender.sv
// serial_byte_sender: drives one byte into the RS232 transmitter using the
// strobe / busy / idle handshake.
//   clk, rst     clock, synchronous active-high reset
//   sendValid    launch request; honoured only while idle and txReady=1
//   sendByte     byte to launch
//   txReady      transmitter idle
//   sendDone_c   combinational: transmitter has gone busy and is idle again
//   txByte       registered byte to the transmitter, held between strobes
//   startTx      registered one-cycle transmit strobe
module serial_byte_sender
  import serial_command_initiator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sendValid,
  input  logic [BYTE_W-1:0] sendByte,
  input  logic              txReady,
  output logic              sendDone_c,
  output logic [BYTE_W-1:0] txByte,
  output logic              startTx
);

  senderPhase_e      phase, phaseNext;
  logic [BYTE_W-1:0] txByteNext;
  logic              startTxNext;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= TX_IDLE;
      txByte  <= '0;
      startTx <= 1'b0;
    end else begin
      phase   <= phaseNext;
      txByte  <= txByteNext;
      startTx <= startTxNext;
    end
  end

  // Launch only when the transmitter reports idle, then see busy before idle.
  always_comb begin
    phaseNext   = phase;
    txByteNext  = txByte;
    startTxNext = 1'b0;
    case (phase)
      TX_IDLE: begin
        if (sendValid && txReady) begin
          txByteNext  = sendByte;
          startTxNext = 1'b1;
          phaseNext   = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (!txReady) phaseNext = TX_WAIT_IDLE;
      TX_WAIT_IDLE: if (txReady) phaseNext = TX_IDLE;
      default:      phaseNext = TX_IDLE;
    endcase
  end

  assign sendDone_c = (phase == TX_WAIT_IDLE) && txReady;

endmodule

// File: rtl/serial_command_initiator.sv
// serial_command_initiator: turns a word read/write request into a serial
// command frame, collects the responder's reply and reports the result.
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (ready = idle)
//   req_write, req_address, req_data request fields, latched on accept
//   resp_valid                       one-cycle completion pulse
//   resp_data                        last read word, held otherwise
//   resp_error                       timeout or bad ack, valid with resp_valid
//   TX, start_TX, TX_ready           RS232 transmitter interface
//   RX, RX_ready                     RS232 receiver interface
module serial_command_initiator
  import serial_command_initiator_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 2500000,
  parameter logic [BYTE_W-1:0] ACK_BYTE       = ACK_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_address,
  input  logic [WORD_W-1:0] req_data,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_error,
  output logic [BYTE_W-1:0] TX,
  output logic              start_TX,
  input  logic              TX_ready,
  input  logic [BYTE_W-1:0] RX,
  input  logic              RX_ready
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  initiatorState_e   state, stateNext;
  memRequest_t       pendingReq, pendingReqNext;
  logic [IDX_W-1:0]  byteIdx, byteIdxNext;
  logic [TIMER_W-1:0] timer, timerNext;
  // Only the three most recent reply bytes need keeping; the fourth comes straight from RX.
  logic [23:0]       rxShift, rxShiftNext;
  logic [BYTE_W-1:0] curByte, curByteNext;
  logic [WORD_W-1:0] respDataNext;
  logic              respErrorNext;
  logic              reqReadyNext;
  logic              respValidNext;
  logic              sendValid;
  logic              sendDone_c;

  serial_byte_sender u_sender (
    .clk        (clk),
    .rst        (rst),
    .sendValid  (sendValid),
    .sendByte   (curByte),
    .txReady    (TX_ready),
    .sendDone_c (sendDone_c),
    .txByte     (TX),
    .startTx    (start_TX)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pendingReq <= '0;
      byteIdx    <= '0;
      timer      <= '0;
      rxShift    <= '0;
      curByte    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= stateNext;
      pendingReq <= pendingReqNext;
      byteIdx    <= byteIdxNext;
      timer      <= timerNext;
      rxShift    <= rxShiftNext;
      curByte    <= curByteNext;
      req_ready  <= reqReadyNext;
      resp_valid <= respValidNext;
      resp_data  <= respDataNext;
      resp_error <= respErrorNext;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    stateNext      = state;
    pendingReqNext = pendingReq;
    byteIdxNext    = byteIdx;
    timerNext      = timer;
    rxShiftNext    = rxShift;
    curByteNext    = curByte;
    respDataNext   = resp_data;
    respErrorNext  = resp_error;
    sendValid      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          pendingReqNext = '{write: req_write, address: req_address, data: req_data};
          byteIdxNext    = '0;
          rxShiftNext    = '0;
          stateNext      = S_LOAD;
        end
      end
      S_LOAD: begin
        curByteNext = frameByte(pendingReq, byteIdx);
        stateNext   = S_SEND;
      end
      S_SEND: begin
        sendValid = 1'b1;
        if (TX_ready) stateNext = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!TX_ready) stateNext = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (sendDone_c) begin
          if (byteIdx == lastFrameIdx(pendingReq.write)) begin
            byteIdxNext = '0;
            timerNext   = '0;
            stateNext   = S_RECV;
          end else begin
            byteIdxNext = byteIdx + IDX_W'(1);
            stateNext   = S_LOAD;
          end
        end
      end
      S_RECV: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (RX_ready) begin
          rxShiftNext = {rxShift[15:0], RX};
          timerNext   = '0;
          if (pendingReq.write) begin
            respErrorNext = (RX != ACK_BYTE);
            stateNext     = S_DONE;
          end else if (byteIdx == IDX_W'(READ_REPLY_BYTES - 1)) begin
            respDataNext  = {rxShift, RX};
            respErrorNext = 1'b0;
            stateNext     = S_DONE;
          end else begin
            byteIdxNext = byteIdx + IDX_W'(1);
          end
        end else if (timer == TIMER_LAST) begin
          respErrorNext = 1'b1;
          stateNext     = S_DONE;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign reqReadyNext  = (stateNext == S_IDLE);
  assign respValidNext = (stateNext == S_DONE);

endmodule
